down_counter_la: RTL and testbench

DOWN_COUNTER_LA -- requirements
Module: down_counter_LA

---
 rtl/down_counter_la.sv | 129 ++++++++++++
 tb/tb_down_counter_la.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/down_counter_la.sv
// rtl/down_counter_la.sv - loadable down counter driven by two free-running prescalers
// Build option: define AUTO_RELOAD_EN to reload the start value on expiry instead of stopping.
module down_counter_la #(
  parameter int W     = 5,
  parameter int PRE_A = 11,
  parameter int PRE_B = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tick_a,
  output logic         tick_b,
  output logic         busy,
  output logic         done
);

  localparam int AW = (PRE_A > 1) ? $clog2(PRE_A) : 1;
  localparam int BW = (PRE_B > 1) ? $clog2(PRE_B) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [AW-1:0]  r_pre_a;
  logic [BW-1:0]  r_pre_b;
  logic [W-1:0]   r_count;
  logic [W-1:0]   r_reload;
  logic           r_done;

  logic           w_active;
  logic           w_tick;
  logic           w_expire;
  logic [W-1:0]   w_expire_val;

  // Prescalers only advance, and ticks only appear, while running and enabled.
  assign w_active = (r_state == S_RUN) && en;
  assign tick_a   = w_active && (r_pre_a == AW'(PRE_A - 1));
  assign tick_b   = w_active && (r_pre_b == BW'(PRE_B - 1));
  // Coincident ticks merge into a single decrement.
  assign w_tick   = tick_a || tick_b;
  assign w_expire = w_tick && (r_count == W'(1));

`ifdef AUTO_RELOAD_EN
  assign w_expire_val = r_reload;
`else
  assign w_expire_val = '0;
  logic w_unused_reload;
  assign w_unused_reload = ^r_reload;
`endif

  assign count = r_count;
  assign busy  = (r_state == S_RUN);
  assign done  = r_done;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: load wins everywhere; a zero load parks in IDLE without a done pulse.
  always_comb begin
    w_next = r_state;
    if (load) begin
      w_next = (load_val != '0) ? S_RUN : S_IDLE;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_expire) begin
`ifdef AUTO_RELOAD_EN
            w_next = S_RUN;
`else
            w_next = S_DONE;
`endif
          end
        end
        S_DONE:  w_next = S_IDLE;
        default: w_next = r_state;
      endcase
    end
  end

  // Prescalers: cleared by load and outside RUN, frozen when en is low, wrap at modulus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre_a <= '0;
      r_pre_b <= '0;
    end else if (load || (r_state != S_RUN)) begin
      r_pre_a <= '0;
      r_pre_b <= '0;
    end else if (en) begin
      r_pre_a <= (r_pre_a == AW'(PRE_A - 1)) ? '0 : r_pre_a + 1'b1;
      r_pre_b <= (r_pre_b == BW'(PRE_B - 1)) ? '0 : r_pre_b + 1'b1;
    end
  end

  // Count, reload register and done pulse; count saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        r_count  <= load_val;
        r_reload <= load_val;
      end else if (w_tick && (r_count != '0)) begin
        if (w_expire) begin
          r_done  <= 1'b1;
          r_count <= w_expire_val;
        end else begin
          r_count <= r_count - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_down_counter_la.sv
// tb/tb_down_counter_la.sv - scoreboard bench for down_counter_la against an elapsed-cycle model
module tb_down_counter_la;

  localparam int W  = 5;
  localparam int PA = 11;
  localparam int PB = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic [W-1:0] count;
  logic         tick_a;
  logic         tick_b;
  logic         busy;
  logic         done;

  down_counter_la #(.W(W), .PRE_A(PA), .PRE_B(PB)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .count    (count),
    .tick_a   (tick_a),
    .tick_b   (tick_b),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] c;
    logic         ta;
    logic         tb;
    logic         bz;
    logic         dn;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Model: countdown state plus the number of enabled RUN cycles since the last load.
  bit m_run;
  int m_count;
  int m_reload;
  int m_k;
  bit m_done;

`ifdef AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs this cycle should show, then apply the edge.
  task automatic step(input bit r, input bit ld, input int v, input bit e);
    exp_t x;
    bit   ta;
    bit   tb2;
    @(posedge clk);
    #1;
    rst      = r;
    load     = ld;
    load_val = v[W-1:0];
    en       = e;
    if (r) begin
      m_run = 0; m_count = 0; m_reload = 0; m_k = 0; m_done = 0;
    end
    ta  = !r && m_run && e && ((m_k % PA) == PA - 1);
    tb2 = !r && m_run && e && ((m_k % PB) == PB - 1);
    x.c  = m_count[W-1:0];
    x.ta = ta;
    x.tb = tb2;
    x.bz = m_run;
    x.dn = m_done;
    q.push_back(x);
    if (!r) begin
      if (ld) begin
        m_count = v; m_reload = v; m_k = 0; m_run = (v != 0); m_done = 0;
      end else begin
        m_done = 0;
        if (m_run && e) begin
          if ((ta || tb2) && m_count != 0) begin
            if (m_count == 1) begin
              m_done = 1;
              if (AUTO) begin
                m_count = m_reload;
              end else begin
                m_count = 0;
                m_run   = 0;
              end
            end else begin
              m_count = m_count - 1;
            end
          end
          m_k = m_k + 1;
        end
      end
    end
  endtask

  // Monitor: the DUT presents a full output set every cycle; compare against the queue.
  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("count",  int'(count),  int'(x.c));
      chk("tick_a", int'(tick_a), int'(x.ta));
      chk("tick_b", int'(tick_b), int'(x.tb));
      chk("busy",   int'(busy),   int'(x.bz));
      chk("done",   int'(done),   int'(x.dn));
    end
  end

  initial begin
    rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0;
    m_run = 0; m_count = 0; m_reload = 0; m_k = 0; m_done = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // First load right after reset; count 3 expires on edge 12.
    step(0, 1, 3, 1);
    for (int i = 1; i <= 13; i++) step(0, 0, 0, 1);
    @(negedge clk);
    chk("load3_done_e12",  int'(done),  1);
    chk("load3_count_e12", int'(count), AUTO ? 3 : 0);
    chk("load3_busy_e12",  int'(busy),  AUTO ? 1 : 0);

    // Load 31: sixteen decrements by edge 66 with one merged coincident tick.
    step(0, 1, 31, 1);
    for (int i = 1; i <= 67; i++) step(0, 0, 0, 1);
    @(negedge clk);
    chk("load31_count_e66", int'(count), 15);

    // Reset mid-run aborts without a done pulse.
    step(0, 1, 9, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    @(negedge clk);
    chk("midrun_rst_count", int'(count), 0);
    chk("midrun_rst_busy",  int'(busy),  0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    // en dropped for 20 cycles after edge 4.
    step(0, 1, 5, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 0, 0, 1);

    // Mid-run reload with 7, zero load, and load during DONE.
    step(0, 1, 20, 1);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 1);
    step(0, 1, 7, 1);
    for (int i = 0; i < 40; i++) step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    step(0, 1, 1, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    step(0, 1, 2, 1);
    for (int i = 0; i < 30; i++) step(0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit ld;
      bit e;
      int v;
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 39) == 0);
      e  = ($urandom_range(0, 9) != 0);
      v  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4));
      step(r, ld, v, e);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
